// File: rtl/key_event_queue_if.sv
// Downstream event port of key_event_queue: head key code with a valid/ready handshake.
interface key_event_queue_if;
  logic [3:0] out_addr;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_addr, output out_valid, input out_ready);
  modport slave  (input out_addr, input out_valid, output out_ready);
endinterface

// File: rtl/key_event_queue.sv
// Keypad debouncer that turns each accepted press into one queued register-bank write event.
// Optional auto-repeat while a key is held is built only when KEY_AUTOREPEAT_EN is defined.
module key_event_queue #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int DEPTH           = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             key_code,
  input  logic                   key_press,
  key_event_queue_if.master      out_if,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_code_in, r_code, w_code_nxt;
  logic          r_press_in;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_db_push, w_rpt_hit, w_push_req;

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_full, w_pop, w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_press_in <= 1'b0;
      r_code_in  <= 4'h0;
    end else begin
      r_press_in <= key_press;
      r_code_in  <= key_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_code  <= 4'h0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_cnt counts stable samples already seen; the sample that would make it
  // DEBOUNCE_CYCLES completes the debounce.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_db_push   = 1'b0;
    case (r_state)
      IDLE:
        if (r_press_in) begin
          w_code_nxt  = r_code_in;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = PRESS_WAIT;
        end
      PRESS_WAIT:
        if (!r_press_in) begin
          w_state_nxt = IDLE;
        end else if (r_code_in != r_code) begin
          w_code_nxt = r_code_in;
          w_cnt_nxt  = CW'(1);
        end else if (r_cnt == DB_LAST) begin
          w_db_push   = 1'b1;
          w_state_nxt = HELD;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      HELD:
        if (!r_press_in) begin
          w_cnt_nxt   = CW'(1);
          w_state_nxt = RELEASE_WAIT;
        end
      RELEASE_WAIT:
        if (r_press_in) begin
          w_state_nxt = HELD;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] r_rpt;

  assign w_rpt_hit = (r_state == HELD) && r_press_in && (r_rpt == RPT_LAST);

  // Held outside HELD at zero, so every HELD entry starts a fresh period.
  always_ff @(posedge clk) begin
    if (rst || (r_state != HELD) || !r_press_in || w_rpt_hit) r_rpt <= '0;
    else                                                      r_rpt <= r_rpt + RW'(1);
  end
`else
  assign w_rpt_hit = 1'b0;
`endif

  assign w_push_req = w_db_push | w_rpt_hit;
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_pop      = out_if.out_valid && out_if.out_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  assign out_if.out_valid = (r_count != '0);
  assign out_if.out_addr  = out_if.out_valid ? r_mem[r_rptr] : 4'h0;
  assign count            = r_count;
  assign overflow         = r_overflow;
endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: run-length press model plus event queue, checked every cycle.
module tb_key_event_queue;
  localparam int D = 4, R = 10, DEPTH = 4;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_code = 4'h0;
  logic       key_press = 1'b0;
  logic [2:0] count;
  logic       overflow;

  key_event_queue_if bus();

  key_event_queue #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_press(key_press),
    .out_if(bus), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int first_valid = -1, valid_cycles = 0, t0 = 0;
  logic [3:0] act_log[$];
  logic [3:0] exp_q[$];

  // Model state: a press is accepted after D same-code pressed samples while
  // armed; it re-arms after D released samples in a row.
  logic       m_pin = 1'b0;
  logic [3:0] m_cin = 4'h0;
  int         run_len = 0, zero_run = 0, hold = 0;
  bit         armed = 1'b1;
  logic [3:0] run_code = 4'h0;
  logic [3:0] q[$];
  bit         m_ovf = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_log(string nm);
    chk({nm, "_events"}, act_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_log.size(); i++)
      chk(nm, {28'h0, act_log[i]}, {28'h0, exp_q[i]});
    act_log.delete();
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(logic p, logic [3:0] c, int n);
    key_press = p;
    key_code  = c;
    tick(n);
  endtask

  initial forever begin
    bit push, pop;
    logic [3:0] pcode;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete(); m_ovf = 1'b0; armed = 1'b1;
      run_len = 0; zero_run = 0; hold = 0;
      m_pin = 1'b0; m_cin = 4'h0;
    end else begin
      push = 1'b0; pcode = 4'h0;
      if (armed) begin
        if (!m_pin) run_len = 0;
        else begin
          if (run_len == 0 || m_cin != run_code) begin run_code = m_cin; run_len = 1; end
          else run_len++;
          if (run_len == D) begin
            push = 1'b1; pcode = run_code; armed = 1'b0; zero_run = 0; hold = 0;
          end
        end
      end else if (!m_pin) begin
        zero_run++; hold = 0;
        if (zero_run == D) begin armed = 1'b1; run_len = 0; end
      end else if (zero_run > 0) begin
        zero_run = 0;
      end else begin
        hold++;
        if (AUTOREP && hold == R) begin push = 1'b1; pcode = run_code; hold = 0; end
      end
      pop = (q.size() > 0) && bus.out_ready;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(pcode);
        else m_ovf = 1'b1;
      end
      m_pin = key_press;
      m_cin = key_code;
    end
  end

  initial forever begin
    logic [3:0] exp_addr;
    @(negedge clk);
    exp_addr = (q.size() > 0) ? q[0] : 4'h0;
    chk("out_valid", {31'h0, bus.out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
    chk("out_addr", {28'h0, bus.out_addr}, {28'h0, exp_addr});
    chk("count", {29'h0, count}, q.size());
    chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    if (!rst && bus.out_valid && bus.out_ready) begin
      act_log.push_back(bus.out_addr);
      if (first_valid < 0) first_valid = cyc;
    end
    if (bus.out_valid) valid_cycles++;
  end

  initial begin
    bus.out_ready = 1'b1;
    tick(3);
    chk("rst_valid", {31'h0, bus.out_valid}, 0);
    chk("rst_count", {29'h0, count}, 0);
    chk("rst_overflow", {31'h0, overflow}, 0);
    rst = 1'b0;
    tick(2);

    // Clean press: event visible D+1 cycles after the input changes.
    act_log.delete(); first_valid = -1; valid_cycles = 0; t0 = cyc;
    drive(1'b1, 4'h5, 20);
    drive(1'b0, 4'h0, 10);
    exp_q = {4'h5}; chk_log("clean");
    chk("clean_latency", first_valid, t0 + 5);
    chk("clean_pulse_width", valid_cycles, 1);
    chk("clean_count", {29'h0, count}, 0);

    // Bounce then stable run; then code change inside the debounce window.
    drive(1'b1, 4'hA, 2); drive(1'b0, 4'hA, 1); drive(1'b1, 4'hA, 3); drive(1'b0, 4'hA, 1);
    drive(1'b1, 4'hA, 6); drive(1'b0, 4'h0, 10);
    exp_q = {4'hA}; chk_log("bounce");
    drive(1'b1, 4'h3, 2); drive(1'b1, 4'h7, 6); drive(1'b0, 4'h0, 10);
    exp_q = {4'h7}; chk_log("relatch");

    // Backpressure: fifth event is dropped.
    bus.out_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin drive(1'b1, 4'(c), 6); drive(1'b0, 4'h0, 6); end
    chk("bp_count", {29'h0, count}, 4);
    chk("bp_overflow", {31'h0, overflow}, 1);
    bus.out_ready = 1'b1;
    tick(8);
    exp_q = {4'h1, 4'h2, 4'h3, 4'h4}; chk_log("bp_order");
    chk("bp_overflow_sticky", {31'h0, overflow}, 1);

    // Full FIFO with pop on the push edge.
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    bus.out_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin drive(1'b1, 4'(c), 6); drive(1'b0, 4'h0, 6); end
    chk("full_count", {29'h0, count}, 4);
    key_press = 1'b1; key_code = 4'h6;
    tick(4);
    bus.out_ready = 1'b1;
    tick(1);
    chk("sim_count", {29'h0, count}, 4);
    chk("sim_overflow", {31'h0, overflow}, 0);
    drive(1'b1, 4'h6, 5); drive(1'b0, 4'h0, 10);
    exp_q = {4'h1, 4'h2, 4'h3, 4'h4, 4'h6}; chk_log("sim_order");

    // Reset with events queued and a press mid-debounce.
    bus.out_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin drive(1'b1, 4'(c), 6); drive(1'b0, 4'h0, 6); end
    chk("pre_rst_count", {29'h0, count}, 3);
    drive(1'b1, 4'h9, 2);
    rst = 1'b1; key_press = 1'b0; tick(1); rst = 1'b0;
    chk("mid_rst_valid", {31'h0, bus.out_valid}, 0);
    chk("mid_rst_count", {29'h0, count}, 0);
    chk("mid_rst_overflow", {31'h0, overflow}, 0);
    bus.out_ready = 1'b1;
    tick(12);
    exp_q.delete(); chk_log("mid_rst");

    // Long hold: one event, or one per repeat period when auto-repeat is built.
    drive(1'b1, 4'h9, 40); drive(1'b0, 4'h0, 10);
    if (AUTOREP) exp_q = {4'h9, 4'h9, 4'h9, 4'h9};
    else         exp_q = {4'h9};
    chk_log("hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
